// File: rtl/ir_queue_pkg.sv
// ---------------------------------------------------------------------------
// ir_queue_pkg
// Shared types for the instruction queue: the RV32I major-opcode enum and the
// decoded control packet delivered to the decode stage.
// ---------------------------------------------------------------------------
package ir_queue_pkg;

    // RV32I major opcodes (bits [6:0] of the instruction word)
    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    // Decoded fields of one instruction word
    typedef struct packed {
        rv32i_opcode opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] i_imm;
        logic [31:0] s_imm;
        logic [31:0] b_imm;
        logic [31:0] u_imm;
        logic [31:0] j_imm;
    } rv32i_ctrl_pkt_t;

endpackage

// File: rtl/ir_queue_if.sv
// ---------------------------------------------------------------------------
// ir_queue_if
// Fetch-side push channel and decode-side pop channel of the instruction
// queue.
//   in_valid/in_ready/in_instr/in_pc   : fetch -> queue
//   out_valid/out_ready                : queue -> decode handshake
//   out_ctrl/out_pc/out_illegal        : decoded head entry
// Handshake: a transfer happens on a posedge where valid and ready are both
// high; valid never depends on ready, and out_valid/in_ready depend only on
// registered occupancy (no combinational path from the other side).
// ---------------------------------------------------------------------------
interface ir_queue_if
    import ir_queue_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    rv32i_ctrl_pkt_t out_ctrl;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;

    // Fetch and decode stages (the environment around the queue)
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_ctrl, out_pc, out_illegal
    );

    // The queue itself
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_ctrl, out_pc, out_illegal
    );
endinterface

// File: rtl/ir_queue_decode.sv
// ---------------------------------------------------------------------------
// ir_decode
// Purely combinational RV32I field extractor.
//   instr_i   : 32-bit instruction word
//   ctrl_o    : decoded fields and all immediate formats
//   illegal_o : opcode is not one of the rv32i_opcode values
// ---------------------------------------------------------------------------
module ir_decode
    import ir_queue_pkg::*;
(
    input  logic [31:0]     instr_i,
    output rv32i_ctrl_pkt_t ctrl_o,
    output logic            illegal_o
);
    always_comb begin
        ctrl_o        = '0;
        ctrl_o.opcode = rv32i_opcode'(instr_i[6:0]);
        ctrl_o.funct3 = instr_i[14:12];
        ctrl_o.funct7 = instr_i[31:25];
        ctrl_o.rs1    = instr_i[19:15];
        ctrl_o.rs2    = instr_i[24:20];
        ctrl_o.rd     = instr_i[11:7];
        ctrl_o.i_imm  = {{20{instr_i[31]}}, instr_i[31:20]};
        ctrl_o.s_imm  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        ctrl_o.b_imm  = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
        ctrl_o.u_imm  = {instr_i[31:12], 12'h000};
        ctrl_o.j_imm  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
    end

    always_comb begin
        illegal_o = 1'b1;
        case (instr_i[6:0])
            op_lui, op_auipc, op_jal, op_jalr, op_br,
            op_load, op_store, op_imm, op_reg, op_csr: illegal_o = 1'b0;
            default:                                   illegal_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/ir_queue.sv
// ---------------------------------------------------------------------------
// ir_queue
// DEPTH-entry instruction queue between fetch and decode, with the head entry
// decoded combinationally.
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : drop every queued entry (redirect); beats push/pop
//   bus        : ir_queue_if.slave push/pop channels and decoded head
//   count      : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module ir_queue
    import ir_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    ir_queue_if.slave                bus,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]     instr_q [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic            push, pop;
    rv32i_ctrl_pkt_t head_ctrl;
    logic            head_illegal;

    // Ready/valid come only from registered occupancy: a full queue refuses a
    // push even when the head is popped in the same cycle.
    assign bus.in_ready  = (count_q < CNT_W'(DEPTH));
    assign bus.out_valid = (count_q != '0);
    assign push = bus.in_valid  & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push && !flush) begin
                instr_q[wr_ptr_q] <= bus.in_instr;
                pc_q[wr_ptr_q]    <= bus.in_pc;
            end
        end
    end

    ir_decode u_decode (
        .instr_i   (instr_q[rd_ptr_q]),
        .ctrl_o    (head_ctrl),
        .illegal_o (head_illegal)
    );

    // Head outputs are held at zero while the queue is empty.
    assign bus.out_ctrl    = bus.out_valid ? head_ctrl : '0;
    assign bus.out_pc      = bus.out_valid ? pc_q[rd_ptr_q] : '0;
    assign bus.out_illegal = bus.out_valid & head_illegal;
    assign count           = count_q;
endmodule

// File: tb/tb_ir_queue.sv
module tb_ir_queue;
  import ir_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int PKT_W = $bits(rv32i_ctrl_pkt_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [$clog2(DEPTH):0] count;
  always #5 clk = ~clk;

  ir_queue_if #(.XLEN(XLEN)) bus ();

  ir_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // Queue contents as {instr, pc}; head is element 0.
  logic [32+XLEN-1:0] exp_q[$];
  bit model_live = 1'b0;

  function automatic bit is_legal(input logic [6:0] op);
    logic [6:0] legal [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                               7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    foreach (legal[i]) if (legal[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [PKT_W-1:0] model_decode(input logic [31:0] d);
    rv32i_ctrl_pkt_t p;
    logic [11:0] i_f;
    logic [11:0] s_f;
    logic [12:0] b_f;
    logic [20:0] j_f;
    i_f = d[31:20];
    s_f = {d[31:25], d[11:7]};
    b_f = {d[31], d[7], d[30:25], d[11:8], 1'b0};
    j_f = {d[31], d[19:12], d[20], d[30:21], 1'b0};
    p.opcode = rv32i_opcode'(d[6:0]);
    p.funct3 = d[14:12];
    p.funct7 = d[31:25];
    p.rs1    = d[19:15];
    p.rs2    = d[24:20];
    p.rd     = d[11:7];
    p.i_imm  = 32'($signed(i_f));
    p.s_imm  = 32'($signed(s_f));
    p.b_imm  = 32'($signed(b_f));
    p.u_imm  = d[31:12] << 12;
    p.j_imm  = 32'($signed(j_f));
    return p;
  endfunction

  // Model advances on the same edge as the DUT; inputs are stable here.
  always @(posedge clk) begin
    bit do_push, do_pop;
    if (!rst_n) begin
      exp_q.delete();
      model_live = 1'b1;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      do_push = bus.in_valid && (exp_q.size() < DEPTH);
      do_pop  = bus.out_ready && (exp_q.size() != 0);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({bus.in_instr, bus.in_pc});
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] hi;
    logic [XLEN-1:0] hp;
    if (model_live) begin
      check("count", 256'(count), 256'(exp_q.size()));
      check("in_ready", 256'(bus.in_ready), 256'(exp_q.size() < DEPTH));
      check("out_valid", 256'(bus.out_valid), 256'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        {hi, hp} = exp_q[0];
        check("out_pc", 256'(bus.out_pc), 256'(hp));
        check("out_ctrl", 256'(bus.out_ctrl), 256'(model_decode(hi)));
        check("out_illegal", 256'(bus.out_illegal), 256'(!is_legal(hi[6:0])));
      end else begin
        check("out_pc_empty", 256'(bus.out_pc), 256'(0));
        check("out_ctrl_empty", 256'(bus.out_ctrl), 256'(0));
        check("out_illegal_empty", 256'(bus.out_illegal), 256'(0));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input bit v, input logic [31:0] instr, input logic [XLEN-1:0] pc,
                      input bit rdy, input bit fl);
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    flush         = fl;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                             7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  initial begin
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    check("rst_count", 256'(count), 256'(0));
    check("rst_out_valid", 256'(bus.out_valid), 256'(0));
    check("rst_in_ready", 256'(bus.in_ready), 256'(1));
    check("rst_out_ctrl", 256'(bus.out_ctrl), 256'(0));

    // addi x1,x0,5 at 0x100
    step(1, 32'h00500093, 32'h100, 0, 0);
    check("addi_valid", 256'(bus.out_valid), 256'(1));
    check("addi_opcode", 256'(bus.out_ctrl.opcode), 256'(7'h13));
    check("addi_rd", 256'(bus.out_ctrl.rd), 256'(1));
    check("addi_rs1", 256'(bus.out_ctrl.rs1), 256'(0));
    check("addi_i_imm", 256'(bus.out_ctrl.i_imm), 256'(32'd5));
    check("addi_pc", 256'(bus.out_pc), 256'(32'h100));
    check("addi_illegal", 256'(bus.out_illegal), 256'(0));
    step(0, 0, 0, 1, 0);
    check("addi_pop_count", 256'(count), 256'(0));

    // beq x0,x0,-4 then lui x5 (beq popped while lui pushed)
    step(1, 32'hFE000EE3, 32'h104, 0, 0);
    check("beq_b_imm", 256'(bus.out_ctrl.b_imm), 256'(32'hFFFFFFFC));
    check("beq_funct3", 256'(bus.out_ctrl.funct3), 256'(0));
    step(1, 32'h123452B7, 32'h108, 1, 0);
    check("lui_u_imm", 256'(bus.out_ctrl.u_imm), 256'(32'h12345000));
    check("lui_rd", 256'(bus.out_ctrl.rd), 256'(5));
    check("lui_count", 256'(count), 256'(1));
    step(0, 0, 0, 1, 0);

    // Fill to DEPTH, then prove full blocks push even with a pop
    for (int i = 0; i < DEPTH; i++) step(1, 32'h00000013, 32'(i * 4), 0, 0);
    check("full_count", 256'(count), 256'(DEPTH));
    check("full_in_ready", 256'(bus.in_ready), 256'(0));
    step(1, 32'h00000013, 32'h10, 0, 0);
    check("full_hold_count", 256'(count), 256'(DEPTH));
    check("fifo_pc0", 256'(bus.out_pc), 256'(32'h0));
    step(1, 32'h00000013, 32'h10, 1, 0);
    check("full_pop_count", 256'(count), 256'(DEPTH - 1));
    check("full_pop_in_ready", 256'(bus.in_ready), 256'(1));
    for (int i = 1; i < DEPTH; i++) begin
      check("fifo_pc", 256'(bus.out_pc), 256'(i * 4));
      step(0, 0, 0, 1, 0);
    end
    check("drain_count", 256'(count), 256'(0));

    // Steady push+pop at count 2 across pointer wrap
    step(1, 32'h00000013, 32'h200, 0, 0);
    step(1, 32'h00000013, 32'h204, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 32'h00000013, 32'(32'h208 + 4 * i), 1, 0);
      check("pp_count", 256'(count), 256'(2));
      check("pp_pc", 256'(bus.out_pc), 256'(32'h200 + 4 * (i + 1)));
    end

    // Flush at count 3 with push and pop requested
    step(1, 32'h00000013, 32'h300, 0, 0);
    check("pre_flush_count", 256'(count), 256'(3));
    step(1, 32'h00000093, 32'hDEAD0, 1, 1);
    check("flush_count", 256'(count), 256'(0));
    check("flush_valid", 256'(bus.out_valid), 256'(0));
    check("flush_ctrl", 256'(bus.out_ctrl), 256'(0));
    step(0, 0, 0, 0, 0);
    check("flush_dropped", 256'(count), 256'(0));

    // Illegal opcode, then reset with entries queued
    step(1, 32'h0000007F, 32'h400, 0, 0);
    check("illegal_flag", 256'(bus.out_illegal), 256'(1));
    step(1, 32'h00000013, 32'h404, 0, 0);
    check("pre_rst_count", 256'(count), 256'(2));
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0);
    check("rst2_count", 256'(count), 256'(0));
    check("rst2_valid", 256'(bus.out_valid), 256'(0));
    rst_n = 1'b1;

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      step($urandom_range(0, 2) != 0, rand_instr(), $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
